// File: rtl/mux32_3in.sv
// 3-way operand-forwarding selector with a registered copy of the result.
// MUX32_3IN_SEL_ERR_EN adds a sticky flag for the illegal select code 2'b11.
module mux32_3in #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] ILL_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [WIDTH-1:0] input3,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_err
);

  logic [WIDTH-1:0] out_q_q;
  logic [WIDTH-1:0] out_q_d;

  // A select containing X/Z falls through to the default arm.
  always_comb begin
    out = ILL_VALUE;
    case (op)
      2'b00:   out = input1;
      2'b01:   out = input2;
      2'b10:   out = input3;
      default: out = ILL_VALUE;
    endcase
  end

  always_comb begin
    out_q_d = out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q_q <= '0;
    end else begin
      out_q_q <= out_q_d;
    end
  end

  assign out_q = out_q_q;

`ifdef MUX32_3IN_SEL_ERR_EN
  logic sel_err_q;
  logic sel_err_d;

  always_comb begin
    sel_err_d = sel_err_q | (op == 2'b11);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux32_3in.sv
// Table-driven bench for mux32_3in with a queue scoreboard for out_q.
// Sticky-flag expectations follow MUX32_3IN_SEL_ERR_EN when defined.
module tb_mux32_3in;

`ifdef MUX32_3IN_SEL_ERR_EN
  localparam bit SEL_EN = 1'b1;
`else
  localparam bit SEL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input1;
  logic [31:0] input2;
  logic [31:0] input3;
  logic [1:0]  op;
  logic [31:0] out;
  logic [31:0] out_q;
  logic        sel_err;

  mux32_3in dut (
    .clk    (clk),
    .rst    (rst),
    .input1 (input1),
    .input2 (input2),
    .input3 (input3),
    .op     (op),
    .out    (out),
    .out_q  (out_q),
    .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] exp;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb[$];
  logic        err_m;
  vec_t        vecs[12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    logic [31:0] e;
    @(negedge clk);
    input1 = v.a;
    input2 = v.b;
    input3 = v.c;
    op     = v.op;
    #1;
    chk({tag, ".out"}, out, v.exp);
    sb.push_back(v.exp);
    @(posedge clk);
    if (SEL_EN && !rst && v.op == 2'b11) err_m = 1'b1;
    #1;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s.sb: got empty want entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".out_q"}, out_q, e);
    end
    chk({tag, ".sel_err"}, {31'd0, sel_err}, {31'd0, err_m});
  endtask

  initial begin
    vecs[0]  = '{2'b00, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hAAAAAAAA};
    vecs[1]  = '{2'b01, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hBBBBBBBB};
    vecs[2]  = '{2'b10, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hCCCCCCCC};
    vecs[3]  = '{2'b11, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'h00000000};
    vecs[4]  = '{2'b00, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hAAAAAAAA};
    vecs[5]  = '{2'b10, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
    vecs[6]  = '{2'b01, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    vecs[7]  = '{2'b00, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 32'h00000001};
    vecs[8]  = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[9]  = '{2'b01, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hA5A5A5A5};
    vecs[10] = '{2'b10, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h0F0F0F0F};
    vecs[11] = '{2'b10, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hCCCCCCCC};

    err_m  = 1'b0;
    rst    = 1'b1;
    input1 = 32'hAAAAAAAA;
    input2 = 32'hBBBBBBBB;
    input3 = 32'hCCCCCCCC;
    op     = 2'b00;
    #1;
    chk("rst.out_q", out_q, 32'h0);
    chk("rst.sel_err", {31'd0, sel_err}, 32'h0);
    chk("rst.out_valid", out, 32'hAAAAAAAA);

    // op=11 across an edge while in reset must not set the flag
    op = 2'b11;
    #1;
    chk("rst.out_ill", out, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_op11.sel_err", {31'd0, sel_err}, 32'h0);
    chk("rst_op11.out_q", out_q, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    op  = 2'b00;

    for (int i = 0; i < 12; i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end

    // Mid-cycle reset while out_q holds CCCCCCCC
    chk("pre_rst.out_q", out_q, 32'hCCCCCCCC);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.out_q", out_q, 32'h0);
    chk("async_rst.sel_err", {31'd0, sel_err}, 32'h0);
    err_m = 1'b0;
    sb.delete();
    op = 2'b01;
    #1;
    chk("async_rst.out_track", out, 32'hBBBBBBBB);
    op = 2'b11;
    @(posedge clk);
    #1;
    chk("rst_hold.out_q", out_q, 32'h0);
    chk("rst_hold.sel_err", {31'd0, sel_err}, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    op  = 2'b01;
    #1;
    chk("release.out_q", out_q, 32'h0);

    // input2 change with op=01 held: out follows at once, out_q a clock later
    begin
      vec_t v;
      v = '{2'b01, 32'hAAAAAAAA, 32'h12345678, 32'hCCCCCCCC, 32'h12345678};
      step(v, "in2_chg");
      v = '{2'b11, 32'hAAAAAAAA, 32'h12345678, 32'hCCCCCCCC, 32'h00000000};
      step(v, "post_rst_op11");
      v = '{2'b00, 32'hDEADBEEF, 32'h12345678, 32'hCCCCCCCC, 32'hDEADBEEF};
      step(v, "sticky");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
